// File: rtl/capiano_pkg.sv
// rtl/capiano_pkg.sv - shared fetch FSM encoding and sample/word width constants
package capiano_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 2 * SAMPLE_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous word FIFO with flush and occupancy count
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; the consumer qualifies head with a nonzero count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sample_fetch.sv
// rtl/sample_fetch.sv - SRAM sample fetcher feeding 16-bit samples; SAMPLE_FETCH_LOOP_EN enables looped playback
module sample_fetch
    import capiano_pkg::*;
#(
    parameter int ADDR_W     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   length,
    output logic                read,
    output logic                write,
    output logic [ADDR_W-1:0]   inp_addr,
    input  logic                workdone,
    input  logic [WORD_W-1:0]   out_data,
    input  logic                sample_req,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                busy,
    output logic                underrun
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] remaining;
    logic              half_q;
    logic              drain_low_q;
    logic              drain_pend_q;
    logic [CW-1:0]     fifo_count;
    logic [WORD_W-1:0] fifo_head;
    logic              start_ok;
    logic              space;
    logic              push;
    logic              pop;
    logic              take;
    logic              flush;
`ifdef SAMPLE_FETCH_LOOP_EN
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
`endif

    assign start_ok     = (state == ST_IDLE) && start && !stop && (length != '0);
    assign space        = fifo_count < CW'(FIFO_DEPTH);
    assign sample_valid = fifo_count != '0;
    assign flush        = start_ok || (state == ST_DRAIN);
    assign take         = sample_req && sample_valid && !flush;
    assign pop          = take && half_q;
    assign busy         = state != ST_IDLE;
    assign write        = 1'b0;
    assign sample       = !sample_valid ? '0 :
                          half_q ? fifo_head[WORD_W-1:SAMPLE_W] : fifo_head[SAMPLE_W-1:0];

    always_comb begin
        state_nxt = state;
        read      = 1'b0;
        push      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (stop) begin
                    state_nxt = ST_DRAIN;
                end else if (space) begin
                    read      = 1'b1;
                    state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                read = 1'b1;
                if (stop)           state_nxt = ST_DRAIN;
                else if (!workdone) state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (stop) begin
                    state_nxt = ST_DRAIN;
                end else if (workdone) begin
                    push = 1'b1;
`ifdef SAMPLE_FETCH_LOOP_EN
                    state_nxt = ST_REQ;
`else
                    state_nxt = (remaining == ADDR_W'(1)) ? ST_IDLE : ST_REQ;
`endif
                end
            end
            ST_DRAIN: begin
                if (!drain_pend_q || (!drain_low_q && workdone)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            inp_addr     <= '0;
            remaining    <= '0;
            half_q       <= 1'b0;
            underrun     <= 1'b0;
            drain_low_q  <= 1'b0;
            drain_pend_q <= 1'b0;
`ifdef SAMPLE_FETCH_LOOP_EN
            base_q       <= '0;
            len_q        <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                inp_addr  <= base_addr;
                remaining <= length;
`ifdef SAMPLE_FETCH_LOOP_EN
                base_q    <= base_addr;
                len_q     <= length;
`endif
            end else if (push) begin
                inp_addr  <= inp_addr + 1'b1;
                remaining <= remaining - 1'b1;
`ifdef SAMPLE_FETCH_LOOP_EN
                if (remaining == ADDR_W'(1)) begin
                    inp_addr  <= base_q;
                    remaining <= len_q;
                end
`endif
            end

            if (flush)     half_q <= 1'b0;
            else if (take) half_q <= ~half_q;

            if (start_ok)                                  underrun <= 1'b0;
            else if (sample_req && !sample_valid && busy) underrun <= 1'b1;

            // A request seen in WAIT_ACK may not have dropped workdone yet, so drain waits low-then-high.
            if (state != ST_DRAIN && state_nxt == ST_DRAIN) begin
                drain_low_q  <= (state == ST_WAIT_ACK) && workdone;
                drain_pend_q <= (state == ST_WAIT_ACK) || ((state == ST_WAIT_DONE) && !workdone);
            end else if (!workdone) begin
                drain_low_q  <= 1'b0;
            end
        end
    end

    sample_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (WORD_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_data(out_data),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_sample_fetch.sv
// tb/tb_sample_fetch.sv - randomized self-checking bench for sample_fetch with an SRAM controller model
module tb_sample_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [19:0] base_addr = '0;
    logic [19:0] length = '0;
    logic        read;
    logic        write;
    logic [19:0] inp_addr;
    logic        workdone = 1'b1;
    logic [31:0] out_data = '0;
    logic        sample_req = 1'b0;
    logic [15:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int failures = 0;
    int lat = 4;

    logic        ctl_busy = 1'b0;
    int          ctl_cnt = 0;
    logic [19:0] ctl_addr = '0;
    logic [19:0] addr_log[$];

    always #5 clk = ~clk;

    sample_fetch dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .base_addr(base_addr), .length(length),
        .read(read), .write(write), .inp_addr(inp_addr),
        .workdone(workdone), .out_data(out_data),
        .sample_req(sample_req), .sample(sample), .sample_valid(sample_valid),
        .busy(busy), .underrun(underrun)
    );

    function automatic logic [31:0] data_fn(input logic [19:0] a);
        if (a == 20'h00100) return 32'h22221111;
        if (a == 20'h00101) return 32'h44443333;
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Controller: accepts a read only when idle, drops workdone, answers after lat cycles.
    always @(negedge clk) begin
        if (ctl_busy) begin
            if (ctl_cnt <= 1) begin
                workdone = 1'b1;
                out_data = data_fn(ctl_addr);
                ctl_busy = 1'b0;
            end else begin
                ctl_cnt = ctl_cnt - 1;
            end
        end else if (read && workdone) begin
            ctl_busy = 1'b1;
            ctl_cnt  = lat;
            ctl_addr = inp_addr;
            workdone = 1'b0;
            addr_log.push_back(inp_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_playback(input logic [19:0] b, input int n, input int prob, input string name);
        logic [15:0] exp_s[$];
        logic [19:0] exp_a[$];
        logic [19:0] a;
        logic [31:0] d;
        int idx0;
        int cyc;
        for (int i = 0; i < n; i++) begin
            a = b + 20'(i);
            d = data_fn(a);
            exp_a.push_back(a);
            exp_s.push_back(d[15:0]);
            exp_s.push_back(d[31:16]);
        end
        idx0 = addr_log.size();
        base_addr = b;
        length = 20'(n);
        sample_req = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while ((exp_s.size() != 0 || busy) && cyc < 3000) begin
`ifdef SAMPLE_FETCH_LOOP_EN
            if (exp_s.size() == 0) stop = 1'b1;
`endif
            sample_req = ($urandom_range(99) < prob);
            if (sample_req && sample_valid) begin
                checks++;
                if (exp_s.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra_sample got=%h want=none", name, sample);
                end else begin
                    if (sample !== exp_s[0]) begin
                        failures++;
                        $display("FAIL %s_sample got=%h want=%h", name, sample, exp_s[0]);
                    end
                    void'(exp_s.pop_front());
                end
            end
            tick();
            stop = 1'b0;
            cyc++;
        end
        sample_req = 1'b0;
        checks++;
        if (cyc >= 3000) begin
            failures++;
            $display("FAIL %s_timeout got=%0d samples left want=0", name, exp_s.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle got busy=%0b want=0", name, busy);
        end
        checks++;
`ifdef SAMPLE_FETCH_LOOP_EN
        if (addr_log.size() - idx0 < n) begin
`else
        if (addr_log.size() - idx0 != n) begin
`endif
            failures++;
            $display("FAIL %s_read_count got=%0d want=%0d", name, addr_log.size() - idx0, n);
        end
        for (int i = 0; i < n && idx0 + i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[idx0 + i] !== exp_a[i]) begin
                failures++;
                $display("FAIL %s_addr%0d got=%h want=%h", name, i, addr_log[idx0 + i], exp_a[i]);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_wait_idle got busy=%0b want=0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (read !== 1'b0)         begin failures++; $display("FAIL reset_read got=%0b want=0", read); end
        checks++; if (write !== 1'b0)        begin failures++; $display("FAIL reset_write got=%0b want=0", write); end
        checks++; if (inp_addr !== 20'h0)    begin failures++; $display("FAIL reset_addr got=%h want=0", inp_addr); end
        checks++; if (sample !== 16'h0)      begin failures++; $display("FAIL reset_sample got=%h want=0", sample); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", sample_valid); end
        checks++; if (busy !== 1'b0)         begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
        checks++; if (underrun !== 1'b0)     begin failures++; $display("FAIL reset_underrun got=%0b want=0", underrun); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        lat = 4;
        run_playback(20'h00100, 2, 60, "basic");
    endtask

    task automatic test_zero_length();
        int idx0;
        idx0 = addr_log.size();
        base_addr = 20'h12345;
        length = 20'h0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || addr_log.size() != idx0) begin
            failures++;
            $display("FAIL zero_len got busy=%0b reads=%0d want busy=0 reads=0", busy, addr_log.size() - idx0);
        end
    endtask

    task automatic test_fifo_full();
        int idx0;
        lat = 4;
        idx0 = addr_log.size();
        base_addr = 20'($urandom);
        length = 20'd8;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (80) tick();
        checks++; if (addr_log.size() - idx0 != 4) begin failures++; $display("FAIL full_reads got=%0d want=4", addr_log.size() - idx0); end
        checks++; if (read !== 1'b0)         begin failures++; $display("FAIL full_read got=%0b want=0", read); end
        checks++; if (busy !== 1'b1)         begin failures++; $display("FAIL full_busy got=%0b want=1", busy); end
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%0b want=1", sample_valid); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("full");
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL full_flush got=%0b want=0", sample_valid); end
    endtask

    task automatic test_underrun();
        lat = 3;
        run_playback(20'($urandom), 3, 100, "underrun");
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set got=%0b want=1", underrun); end
        sample_req = 1'b1;
        repeat (3) tick();
        sample_req = 1'b0;
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_sticky got=%0b want=1", underrun); end
        base_addr = 20'($urandom);
        length = 20'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clear got=%0b want=0", underrun); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("underrun_stop");
    endtask

    task automatic test_stop();
        int idx0;
        int cyc;
        lat = 10;
        idx0 = addr_log.size();
        base_addr = 20'($urandom);
        length = 20'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(addr_log.size() == idx0 + 2 && ctl_busy && !read) && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++; if (cyc >= 200) begin failures++; $display("FAIL stop_reach_wait_done got=timeout want=wait_done"); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL stop_valid got=%0b want=0", sample_valid); end
        checks++; if (busy !== 1'b1 || read !== 1'b0) begin failures++; $display("FAIL stop_drain got busy=%0b read=%0b want busy=1 read=0", busy, read); end
        cyc = 0;
        while (!workdone && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_idle got busy=%0b want=0", busy); end
        repeat (5) tick();
        checks++; if (addr_log.size() != idx0 + 2) begin failures++; $display("FAIL stop_no_new_read got=%0d want=2", addr_log.size() - idx0); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL stop_discard got=%0b want=0", sample_valid); end
    endtask

    task automatic test_wrap();
        int idx0;
        lat = 3;
        idx0 = addr_log.size();
        run_playback(20'hFFFFF, 2, 70, "wrap");
        checks++;
        if (addr_log.size() < idx0 + 2) begin
            failures++;
            $display("FAIL wrap_second got=none want=00000");
        end else if (addr_log[idx0 + 1] !== 20'h00000) begin
            failures++;
            $display("FAIL wrap_second got=%h want=00000", addr_log[idx0 + 1]);
        end
`ifdef SAMPLE_FETCH_LOOP_EN
        if (addr_log.size() >= idx0 + 3) begin
            checks++;
            if (addr_log[idx0 + 2] !== 20'hFFFFF) begin
                failures++;
                $display("FAIL wrap_loop_third got=%h want=fffff", addr_log[idx0 + 2]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        int cyc;
        lat = 6;
        base_addr = 20'($urandom);
        length = 20'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!(ctl_busy && read) && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++; if (cyc >= 50) begin failures++; $display("FAIL midrst_reach_wait_ack got=timeout want=wait_ack"); end
        rst = 1'b0;
        #1;
        checks++;
        if ({read, write, inp_addr, sample, sample_valid, busy, underrun} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got read=%0b addr=%h valid=%0b busy=%0b want all zero", read, inp_addr, sample_valid, busy);
        end
        tick();
        rst = 1'b1;
        tick();
        cyc = 0;
        while (ctl_busy && cyc < 50) begin
            tick();
            cyc++;
        end
        run_playback(20'($urandom), 3, 70, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            lat = $urandom_range(2, 6);
            run_playback(20'($urandom), $urandom_range(1, 9), $urandom_range(20, 100), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_fifo_full();
        test_underrun();
        test_stop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sample_fetch.md
SAMPLE_FETCH -- requirements
Module: sample_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 20: SRAM word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: word-FIFO entries, power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins playback.
REQ-006 SHALL have port stop  input  1  one-cycle pulse that aborts playback.
REQ-007 SHALL have port base_addr  input  ADDR_W  first word address, sampled on start.
REQ-008 SHALL have port length  input  ADDR_W  word count, sampled on start; 0 means no fetch.
REQ-009 SHALL have port read  output  1  read request to the SRAM controller.
REQ-010 SHALL have port write  output  1  write request to the SRAM controller, constant 0.
REQ-011 SHALL have port inp_addr  output  ADDR_W  SRAM word address of the current request.
REQ-012 SHALL have port workdone  input  1  controller done level: low while busy, high when finished.
REQ-013 SHALL have port out_data  input  32  controller read data, valid while workdone is high.
REQ-014 SHALL have port sample_req  input  1  consumer pop strobe, one sample per high cycle.
REQ-015 SHALL have port sample  output  16  current sample; low half of a word first, then high half.
REQ-016 SHALL have port sample_valid  output  1  sample holds valid data.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port underrun  output  1  sticky flag: sample_req arrived while sample_valid was low and busy was high.

Function
REQ-019 SHALL implement states IDLE, REQ, WAIT_ACK, WAIT_DONE, DRAIN.
REQ-020 IDLE -> REQ on start with length!=0: latch base_addr into inp_addr and length into the remaining counter; flush the FIFO; clear underrun.
REQ-021 start with length==0 SHALL leave the block in IDLE with no request issued.
REQ-022 REQ SHALL be entered only when FIFO occupancy is below FIFO_DEPTH (the in-flight word counts as an occupied slot); otherwise the block waits in REQ with read low.
REQ-023 read SHALL be high from REQ until the first cycle workdone is sampled low (WAIT_ACK), then drop the next cycle.
REQ-024 WAIT_DONE: on the first cycle workdone is high, push out_data into the FIFO, increment inp_addr modulo 2^ADDR_W, and decrement the remaining counter.
REQ-025 After the push, the block SHALL go to REQ if remaining!=0, else to IDLE (the FIFO keeps draining in IDLE).
REQ-026 Fetch latency SHALL be at most one cycle from a free slot to read high, and one cycle from workdone high to the word becoming visible at sample.
REQ-027 Each FIFO word SHALL yield two samples: out_data[15:0], then out_data[31:16]; the word is popped after the second sample_req.
REQ-028 sample_req while sample_valid is low SHALL not change the FIFO.
REQ-029 sample_req is taken in the same cycle as a push; a simultaneous push into a full FIFO cannot occur (see REQ-022).
REQ-030 stop (or stop coincident with start) SHALL enter DRAIN from any non-IDLE state: read low, wait for workdone high if a request is outstanding, discard that word, flush the FIFO, then go to IDLE; stop in IDLE is ignored.
REQ-031 start while busy SHALL be ignored.

Reset
REQ-032 rst low SHALL asynchronously force IDLE, read=0, write=0, inp_addr=0, sample=0, sample_valid=0, busy=0, underrun=0, an empty FIFO, and a zero remaining counter.
REQ-033 Reset mid-request SHALL abandon the transaction; the first request after reset SHALL still wait for workdone to go low before waiting for high.

Configuration
REQ-034 With SAMPLE_FETCH_LOOP_EN defined, remaining reaching 0 SHALL reload base_addr and length and continue fetching until stop; without it, playback ends per REQ-025.

Structure
REQ-035 State encoding and the sample width constant (16) SHALL live in the shared package capiano_pkg.
REQ-036 The FIFO SHALL be a separate sub-module sample_fifo (synchronous, flush input, count output); the FSM, address logic and counters stay in sample_fetch.

Verification
REQ-037 start base=0x00100 len=2, controller model with 4-cycle latency returning 0x22221111 and 0x44443333 -> addresses 0x00100 and 0x00101, samples 0x1111, 0x2222, 0x3333, 0x4444, then IDLE.
REQ-038 len=8, FIFO_DEPTH=4, no sample_req -> exactly 4 reads issued, read stays low, busy=1.
REQ-039 sample_req held high with empty FIFO while busy -> underrun=1 until the next start.
REQ-040 stop during WAIT_DONE -> no new read, outstanding word discarded, sample_valid=0, IDLE after workdone rises.
REQ-041 base=0xFFFFF len=2 -> second address 0x00000; with SAMPLE_FETCH_LOOP_EN, the third address is 0xFFFFF.
REQ-042 rst pulsed low in WAIT_ACK -> all outputs at reset values immediately; a new start completes normally.
